mac_operand_sequencer: RTL

//   Upstream feeder for the pipelined 4x4 MAC (9-bit accumulator, 1-cycle operand register).

---
 rtl/mac_operand_sequencer_if.sv | 13 +
 rtl/mac_operand_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer_if.sv
// Operand-pair stream into the MAC sequencer.
// A pair transfers on a rising clock edge where s_valid && s_ready; the source holds s_a/s_b stable while s_valid waits.
interface mac_operand_sequencer_if #(
   parameter int DW = 4
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_a;
   logic [DW-1:0] s_b;

   modport master (output s_valid, output s_a, output s_b, input s_ready);
   modport slave  (input s_valid, input s_a, input s_b, output s_ready);
endinterface

// File: rtl/mac_operand_sequencer.sv
// Feeds a 2-edge-latency MAC from a small operand FIFO.
// Each run clears the MAC, streams len pairs into it and pulses done on the cycle the result is final.
module mac_operand_sequencer #(
   parameter int DW    = 4,
   parameter int DEPTH = 4,
   parameter int LENW  = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [LENW-1:0]         len,
   mac_operand_sequencer_if.slave  stream,
   output logic                    mac_rst,
   output logic [DW-1:0]           mac_in1,
   output logic [DW-1:0]           mac_in2,
   output logic                    busy,
   output logic                    done,
   output logic [2:0]              dbg_state
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN1, DRAIN2} state_t;

   state_t            state_q, state_d;
   logic [LENW-1:0]   remaining_q, remaining_d;
   logic [2*DW-1:0]   mem_q [DEPTH];
   logic [2*DW-1:0]   mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              mac_rst_q, mac_rst_d;
   logic [DW-1:0]     mac_in1_q, mac_in1_d;
   logic [DW-1:0]     mac_in2_q, mac_in2_d;
   logic              done_q, done_d;
   logic              full, empty, push, pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = stream.s_valid && !full;
   // No bypass: a pop needs an entry already stored before this edge.
   assign pop   = (state_q == RUN) && !empty && (remaining_q != '0);

   always_comb begin
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = {stream.s_a, stream.s_b};
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      mac_rst_d   = 1'b0;
      done_d      = 1'b0;
      mac_in1_d   = pop ? mem_q[rd_ptr_q][2*DW-1:DW] : '0;
      mac_in2_d   = pop ? mem_q[rd_ptr_q][DW-1:0]    : '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = CLR;
               remaining_d = len;
               mac_rst_d   = 1'b1;
            end
         end
         CLR:    state_d = (remaining_q == '0) ? DRAIN1 : RUN;
         RUN: begin
            if (pop) begin
               remaining_d = remaining_q - LENW'(1);
               if (remaining_q == LENW'(1)) state_d = DRAIN1;
            end
         end
         // Two drain cycles cover the MAC's operand register and accumulator stages.
         DRAIN1: state_d = DRAIN2;
         DRAIN2: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         mac_rst_q   <= 1'b0;
         mac_in1_q   <= '0;
         mac_in2_q   <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mac_rst_q   <= mac_rst_d;
         mac_in1_q   <= mac_in1_d;
         mac_in2_q   <= mac_in2_d;
         done_q      <= done_d;
         mem_q       <= mem_d;
      end
   end

   assign stream.s_ready = !full;
   assign mac_rst        = mac_rst_q;
   assign mac_in1        = mac_in1_q;
   assign mac_in2        = mac_in2_q;
   assign done           = done_q;
   assign busy           = (state_q != IDLE);
   assign dbg_state      = state_q;
endmodule
